// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch responder: 4 byte reads over the arbitrated RAM port
// Optional direct-mapped instruction cache is enabled with `define ICACHE_EN.
module instr_fetcher #(
  parameter int PcWidth        = 32,
  parameter int InstrWidth     = 32,
  parameter int CacheIndexBits = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_empty_from_iq,
  input  logic [PcWidth-1:0]    pc_from_iq,
  input  logic                  is_exception_from_rob,
  output logic                  is_stall_to_iq,
  output logic                  is_finish_to_iq,
  output logic [InstrWidth-1:0] instr_to_iq,
  output logic [PcWidth-1:0]    pc_to_iq,
  output logic                  mem_req_to_arb,
  input  logic                  mem_grant_from_arb,
  output logic [PcWidth-1:0]    mem_addr_to_ram,
  input  logic [7:0]            mem_din_from_ram
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [PcWidth-1:0]    pc_q;
  logic [2:0]            issue_cnt;    // bit 2 set once all four addresses are granted
  logic [1:0]            recv_cnt;
  logic                  cap_pending;  // an address was granted last cycle, its byte is on mem_din now
  logic [23:0]           instr_q;      // bytes 0..2; byte 3 goes straight into the output register
  logic [InstrWidth-1:0] instr_out;
  logic [PcWidth-1:0]    pc_out;
  logic                  issue;
  logic                  last_byte;
  logic                  cache_hit;
  logic [InstrWidth-1:0] cache_rdata;

  assign mem_req_to_arb  = (state == READ) && !issue_cnt[2];
  assign issue           = mem_req_to_arb && mem_grant_from_arb;
  assign last_byte       = (state == READ) && cap_pending && (recv_cnt == 2'd3);
  assign mem_addr_to_ram = pc_q + PcWidth'(issue_cnt[1:0]);
  assign is_stall_to_iq  = (state == READ);
  assign is_finish_to_iq = (state == DONE);
  assign instr_to_iq     = instr_out;
  assign pc_to_iq        = pc_out;

`ifdef ICACHE_EN
  localparam int Entries = 1 << CacheIndexBits;
  localparam int TagW    = PcWidth - CacheIndexBits - 2;

  logic [Entries-1:0]        cache_valid;
  logic [TagW-1:0]           cache_tag  [Entries];
  logic [InstrWidth-1:0]     cache_data [Entries];
  logic [CacheIndexBits-1:0] req_idx;
  logic [CacheIndexBits-1:0] fill_idx;
  logic                      fill;

  assign req_idx     = pc_from_iq[CacheIndexBits+1:2];
  assign fill_idx    = pc_q[CacheIndexBits+1:2];
  assign cache_hit   = cache_valid[req_idx] &&
                       (cache_tag[req_idx] == pc_from_iq[PcWidth-1:CacheIndexBits+2]);
  assign cache_rdata = cache_data[req_idx];
  // A hit also passes through DONE and rewrites identical contents, which is harmless.
  assign fill        = (state == DONE) && !is_exception_from_rob;

  // Valid bits: cleared only by reset, set by a completed fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= '0;
    end else if (fill) begin
      cache_valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage, written in the DONE cycle from the returned instruction.
  always_ff @(posedge clk) begin
    if (fill) begin
      cache_tag[fill_idx]  <= pc_q[PcWidth-1:CacheIndexBits+2];
      cache_data[fill_idx] <= instr_out;
    end
  end
`else
  // No cache storage: every request misses.
  assign cache_hit   = (CacheIndexBits < 0);
  assign cache_rdata = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an exception overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!is_empty_from_iq) next_state = cache_hit ? DONE : READ;
      READ: if (last_byte) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (is_exception_from_rob) next_state = IDLE;
  end

  // Datapath: latch request, count issued/received bytes, assemble the instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      cap_pending <= 1'b0;
      instr_q     <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
    end else if (is_exception_from_rob) begin
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      cap_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!is_empty_from_iq) begin
            pc_q        <= pc_from_iq;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            cap_pending <= 1'b0;
            instr_q     <= '0;
            if (cache_hit) begin
              instr_out <= cache_rdata;
              pc_out    <= pc_from_iq;
            end
          end
        end
        READ: begin
          cap_pending <= issue;
          if (issue) issue_cnt <= issue_cnt + 3'd1;
          if (cap_pending) begin
            recv_cnt <= recv_cnt + 2'd1;
            case (recv_cnt)
              2'd0: instr_q[7:0]   <= mem_din_from_ram;
              2'd1: instr_q[15:8]  <= mem_din_from_ram;
              2'd2: instr_q[23:16] <= mem_din_from_ram;
              default: begin
                instr_out <= {mem_din_from_ram, instr_q};
                pc_out    <= pc_q;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
